// File: rtl/bchecc_seq.sv
`default_nettype none
// ============================================================================
// Module   : bchecc_seq
// Purpose  : Sector sequencer for the BCH ECC engine. One encode or decode
//            pass per start edge: counts data and parity bytes, starts the
//            decode calculation, waits for it and reports status.
// Options  : BCHECC_TIMEOUT_EN - bounds the wait in CALC to TIMEOUT_CYC
//            cycles; on expiry the sector is reported as uncorrectable.
// Revision : 1.0 - initial release
// ============================================================================
module bchecc_seq #(
   parameter int PAR_BYTES   = 13,
   parameter int TIMEOUT_CYC = 4095
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] ecc_ctrl_i,
   input  logic [9:0] ecc_cfg_i,
   input  logic       nfc_vld_i,
   output logic       nfc_rdy_o,
   output logic       par_vld_o,
   input  logic       par_rdy_i,
   output logic       core_clr_o,
   output logic       core_dat_en_o,
   output logic       core_par_en_o,
   output logic       core_calc_o,
   input  logic       core_done_i,
   input  logic [3:0] core_errn_i,
   input  logic       core_fail_i,
   output logic       change_stat_o,
   output logic       ecc_busy_o,
   output logic       ecc_block_o,
   output logic       ecc_error_o,
   output logic       correct_fail_o,
   output logic [3:0] error_cnt_o
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_CLR  = 3'd1,
      S_DATA = 3'd2,
      S_PAR  = 3'd3,
      S_CALC = 3'd4,
      S_RPT  = 3'd5,
      S_DONE = 3'd6
   } state_t;

   localparam logic [9:0]  c_par_last = 10'(PAR_BYTES - 1);
   localparam logic [11:0] c_tmo_last = 12'(TIMEOUT_CYC - 1);

   state_t      state_q, state_d;
   logic        start_q;
   logic        mode_q, mode_d;
   logic [9:0]  cfg_q, cfg_d;
   logic [9:0]  cnt_q, cnt_d;
   logic        err_q, err_d;
   logic        fail_q, fail_d;
   logic [3:0]  errcnt_q, errcnt_d;

   logic        w_start_edge;
   logic        w_abort;
   logic        w_busy;
   logic        w_tmo_hit;
   logic [12:0] w_unused_bits;

   assign w_start_edge = ecc_ctrl_i[0] & ~start_q;
   assign w_abort      = ecc_ctrl_i[2];
   assign w_busy       = (state_q != S_IDLE) && (state_q != S_DONE);

   // Bit 3 of the control word is reserved; the constant is only live in the timeout build.
   assign w_unused_bits = {ecc_ctrl_i[3], c_tmo_last};

`ifdef BCHECC_TIMEOUT_EN
   logic [11:0] tmo_q;

   // Cycle counter for the CALC wait; restarts from zero on every CALC entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_q <= 12'd0;
      end else if (state_q == S_CALC) begin
         tmo_q <= tmo_q + 12'd1;
      end else begin
         tmo_q <= 12'd0;
      end
   end

   assign w_tmo_hit = (tmo_q == c_tmo_last);
`else
   assign w_tmo_hit = 1'b0;
`endif

   // State, counters, latched command and reported status.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         start_q  <= 1'b0;
         mode_q   <= 1'b0;
         cfg_q    <= 10'd0;
         cnt_q    <= 10'd0;
         err_q    <= 1'b0;
         fail_q   <= 1'b0;
         errcnt_q <= 4'd0;
      end else begin
         state_q  <= state_d;
         start_q  <= ecc_ctrl_i[0];
         mode_q   <= mode_d;
         cfg_q    <= cfg_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
         fail_q   <= fail_d;
         errcnt_q <= errcnt_d;
      end
   end

   // Next-state logic and per-state handshake/strobe outputs.
   always_comb begin
      state_d       = state_q;
      mode_d        = mode_q;
      cfg_d         = cfg_q;
      cnt_d         = cnt_q;
      err_d         = err_q;
      fail_d        = fail_q;
      errcnt_d      = errcnt_q;
      nfc_rdy_o     = 1'b0;
      par_vld_o     = 1'b0;
      core_clr_o    = 1'b0;
      core_dat_en_o = 1'b0;
      core_par_en_o = 1'b0;
      core_calc_o   = 1'b0;
      change_stat_o = 1'b0;

      case (state_q)
         S_IDLE, S_DONE: begin
            // Abort in the same cycle as a start edge suppresses the start.
            if (w_start_edge && !w_abort) begin
               mode_d  = ecc_ctrl_i[1];
               cfg_d   = ecc_cfg_i;
               state_d = S_CLR;
            end
         end
         S_CLR: begin
            core_clr_o = 1'b1;
            cnt_d      = 10'd0;
            state_d    = S_DATA;
         end
         S_DATA: begin
            nfc_rdy_o = 1'b1;
            if (nfc_vld_i) begin
               core_dat_en_o = 1'b1;
               if (cnt_q == cfg_q) begin
                  cnt_d   = 10'd0;
                  state_d = S_PAR;
               end else begin
                  cnt_d = cnt_q + 10'd1;
               end
            end
         end
         S_PAR: begin
            if (!mode_q) begin
               // Encode: core shifts parity out toward the NFC.
               par_vld_o = 1'b1;
               if (par_rdy_i) begin
                  core_par_en_o = 1'b1;
                  if (cnt_q == c_par_last) begin
                     cnt_d    = 10'd0;
                     err_d    = 1'b0;
                     fail_d   = 1'b0;
                     errcnt_d = 4'd0;
                     state_d  = S_RPT;
                  end else begin
                     cnt_d = cnt_q + 10'd1;
                  end
               end
            end else begin
               // Decode: stored parity comes in from the NFC.
               nfc_rdy_o = 1'b1;
               if (nfc_vld_i) begin
                  core_par_en_o = 1'b1;
                  if (cnt_q == c_par_last) begin
                     cnt_d       = 10'd0;
                     core_calc_o = 1'b1;
                     state_d     = S_CALC;
                  end else begin
                     cnt_d = cnt_q + 10'd1;
                  end
               end
            end
         end
         S_CALC: begin
            if (core_done_i) begin
               err_d    = (core_errn_i != 4'd0) | core_fail_i;
               fail_d   = core_fail_i;
               errcnt_d = core_errn_i;
               state_d  = S_RPT;
            end else if (w_tmo_hit) begin
               err_d    = 1'b1;
               fail_d   = 1'b1;
               errcnt_d = 4'd0;
               state_d  = S_RPT;
            end
         end
         S_RPT: begin
            change_stat_o = 1'b1;
            state_d       = S_DONE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Abort drops every handshake and strobe of the current cycle and
      // leaves the previously reported status untouched.
      if (w_abort && w_busy) begin
         state_d       = S_IDLE;
         cnt_d         = 10'd0;
         err_d         = err_q;
         fail_d        = fail_q;
         errcnt_d      = errcnt_q;
         nfc_rdy_o     = 1'b0;
         par_vld_o     = 1'b0;
         core_clr_o    = 1'b0;
         core_dat_en_o = 1'b0;
         core_par_en_o = 1'b0;
         core_calc_o   = 1'b0;
         change_stat_o = 1'b0;
      end
   end

   assign ecc_busy_o     = w_busy;
   assign ecc_block_o    = (state_q == S_DONE);
   assign ecc_error_o    = err_q;
   assign correct_fail_o = fail_q;
   assign error_cnt_o    = errcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_bchecc_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_bchecc_seq
// Purpose  : Directed self-checking bench for bchecc_seq (encode, decode,
//            fail report, abort, stalls, 1-byte sector, async reset and,
//            when BCHECC_TIMEOUT_EN is defined, the CALC timeout).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bchecc_seq;

   localparam int PAR = 13;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] ecc_ctrl_i = 4'd0;
   logic [9:0] ecc_cfg_i = 10'd0;
   logic       nfc_vld_i = 1'b0;
   logic       nfc_rdy_o;
   logic       par_vld_o;
   logic       par_rdy_i = 1'b0;
   logic       core_clr_o;
   logic       core_dat_en_o;
   logic       core_par_en_o;
   logic       core_calc_o;
   logic       core_done_i = 1'b0;
   logic [3:0] core_errn_i = 4'd0;
   logic       core_fail_i = 1'b0;
   logic       change_stat_o;
   logic       ecc_busy_o;
   logic       ecc_block_o;
   logic       ecc_error_o;
   logic       correct_fail_o;
   logic [3:0] error_cnt_o;

   int checks = 0;
   int errors = 0;
   int n_dat, n_par, n_calc, n_wait;

   bchecc_seq #(
      .PAR_BYTES   (PAR),
      .TIMEOUT_CYC (16)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .ecc_ctrl_i     (ecc_ctrl_i),
      .ecc_cfg_i      (ecc_cfg_i),
      .nfc_vld_i      (nfc_vld_i),
      .nfc_rdy_o      (nfc_rdy_o),
      .par_vld_o      (par_vld_o),
      .par_rdy_i      (par_rdy_i),
      .core_clr_o     (core_clr_o),
      .core_dat_en_o  (core_dat_en_o),
      .core_par_en_o  (core_par_en_o),
      .core_calc_o    (core_calc_o),
      .core_done_i    (core_done_i),
      .core_errn_i    (core_errn_i),
      .core_fail_i    (core_fail_i),
      .change_stat_o  (change_stat_o),
      .ecc_busy_o     (ecc_busy_o),
      .ecc_block_o    (ecc_block_o),
      .ecc_error_o    (ecc_error_o),
      .correct_fail_o (correct_fail_o),
      .error_cnt_o    (error_cnt_o)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Start edge, then scramble cfg/mode to show they are latched at start.
   task automatic start_sector(input logic mode, input logic [9:0] cfg);
      ecc_ctrl_i = {2'b00, mode, 1'b1};
      ecc_cfg_i  = cfg;
      tick();
      check("clr_pulse", {31'd0, core_clr_o}, 32'd1);
      check("busy_in_clr", {31'd0, ecc_busy_o}, 32'd1);
      ecc_ctrl_i = {2'b00, ~mode, 1'b0};
      ecc_cfg_i  = ~cfg;
      tick();
      check("clr_one_cycle", {31'd0, core_clr_o}, 32'd0);
   endtask

   // Drive data and parity until PAR parity strobes were seen; optional stalls.
   task automatic stream(input bit stall, output int dat, output int par, output int calc);
      dat = 0; par = 0; calc = 0;
      for (int c = 0; c < 4000; c++) begin
         nfc_vld_i = stall ? ((c % 2) == 0) : 1'b1;
         par_rdy_i = stall ? ((c % 3) != 0) : 1'b1;
         #1;
         if (core_dat_en_o) dat++;
         if (core_par_en_o) par++;
         if (core_calc_o)   calc++;
         @(posedge clk);
         #1;
         if (par >= PAR) break;
      end
      nfc_vld_i = 1'b0;
      par_rdy_i = 1'b0;
   endtask

   initial begin
      // ---------------- reset state ----------------
      tick(); tick();
      rst = 1'b0;
      tick();
      check("rst_busy",   {31'd0, ecc_busy_o},     32'd0);
      check("rst_block",  {31'd0, ecc_block_o},    32'd0);
      check("rst_stat",   {31'd0, change_stat_o},  32'd0);
      check("rst_error",  {31'd0, ecc_error_o},    32'd0);
      check("rst_fail",   {31'd0, correct_fail_o}, 32'd0);
      check("rst_cnt",    {28'd0, error_cnt_o},    32'd0);
      check("rst_rdy",    {31'd0, nfc_rdy_o},      32'd0);
      check("rst_parvld", {31'd0, par_vld_o},      32'd0);

      // ---------------- encode 512 bytes, no stalls ----------------
      start_sector(1'b0, 10'd511);
      stream(1'b0, n_dat, n_par, n_calc);
      check("enc_dat_cnt",  n_dat,  512);
      check("enc_par_cnt",  n_par,  13);
      check("enc_calc_cnt", n_calc, 0);
      check("enc_stat",     {31'd0, change_stat_o},  32'd1);
      check("enc_error",    {31'd0, ecc_error_o},    32'd0);
      check("enc_fail",     {31'd0, correct_fail_o}, 32'd0);
      check("enc_cnt",      {28'd0, error_cnt_o},    32'd0);
      tick();
      check("enc_stat_once", {31'd0, change_stat_o}, 32'd0);
      check("enc_block",     {31'd0, ecc_block_o},   32'd1);
      check("enc_busy",      {31'd0, ecc_busy_o},    32'd0);

      // ---------------- decode 512 bytes, stalls, errn=3 ----------------
      start_sector(1'b1, 10'd511);
      check("dec_block_clr", {31'd0, ecc_block_o}, 32'd0);
      stream(1'b1, n_dat, n_par, n_calc);
      check("dec_dat_cnt",  n_dat,  512);
      check("dec_par_cnt",  n_par,  13);
      check("dec_calc_cnt", n_calc, 1);
      check("dec_calc_busy", {31'd0, ecc_busy_o},    32'd1);
      check("dec_calc_nost", {31'd0, change_stat_o}, 32'd0);
      core_done_i = 1'b1; core_errn_i = 4'd3; core_fail_i = 1'b0;
      tick();
      core_done_i = 1'b0; core_errn_i = 4'd9; core_fail_i = 1'b1;
      check("dec_stat",  {31'd0, change_stat_o},  32'd1);
      check("dec_error", {31'd0, ecc_error_o},    32'd1);
      check("dec_fail",  {31'd0, correct_fail_o}, 32'd0);
      check("dec_cnt",   {28'd0, error_cnt_o},    32'd3);
      tick();
      core_errn_i = 4'd0; core_fail_i = 1'b0;
      check("dec_block",    {31'd0, ecc_block_o}, 32'd1);
      check("dec_cnt_hold", {28'd0, error_cnt_o}, 32'd3);

      // ---------------- decode 8 bytes, uncorrectable ----------------
      start_sector(1'b1, 10'd7);
      stream(1'b1, n_dat, n_par, n_calc);
      check("fail_dat_cnt", n_dat, 8);
      for (int i = 0; i < 5; i++) tick();
      check("calc_wait_busy", {31'd0, ecc_busy_o},    32'd1);
      check("calc_wait_nost", {31'd0, change_stat_o}, 32'd0);
      core_done_i = 1'b1; core_errn_i = 4'd0; core_fail_i = 1'b1;
      tick();
      core_done_i = 1'b0; core_fail_i = 1'b0;
      check("fail_stat",  {31'd0, change_stat_o},  32'd1);
      check("fail_error", {31'd0, ecc_error_o},    32'd1);
      check("fail_fail",  {31'd0, correct_fail_o}, 32'd1);
      check("fail_cnt",   {28'd0, error_cnt_o},    32'd0);
      tick();
      check("fail_block", {31'd0, ecc_block_o}, 32'd1);

      // ---------------- abort at data byte 100 ----------------
      start_sector(1'b0, 10'd511);
      check("abort_block_clr",  {31'd0, ecc_block_o}, 32'd0);
      check("abort_error_hold", {31'd0, ecc_error_o}, 32'd1);
      n_dat = 0;
      for (int i = 0; i < 100; i++) begin
         nfc_vld_i = 1'b1;
         if (i == 50) ecc_ctrl_i[0] = 1'b1;
         #1;
         if (core_dat_en_o) n_dat++;
         tick();
      end
      check("abort_pre_cnt", n_dat, 100);
      check("busy_edge_ign", {31'd0, core_clr_o}, 32'd0);
      ecc_ctrl_i[2] = 1'b1;
      #1;
      check("abort_rdy_drop", {31'd0, nfc_rdy_o},     32'd0);
      check("abort_en_drop",  {31'd0, core_dat_en_o}, 32'd0);
      tick();
      check("abort_idle_busy",  {31'd0, ecc_busy_o},     32'd0);
      check("abort_idle_block", {31'd0, ecc_block_o},    32'd0);
      check("abort_no_stat",    {31'd0, change_stat_o},  32'd0);
      check("abort_fail_hold",  {31'd0, correct_fail_o}, 32'd1);
      ecc_ctrl_i = 4'd0; nfc_vld_i = 1'b0;
      tick();
      // Abort together with a start edge: start is suppressed.
      ecc_ctrl_i = 4'b0101;
      tick();
      check("abort_start_clr",  {31'd0, core_clr_o}, 32'd0);
      check("abort_start_busy", {31'd0, ecc_busy_o}, 32'd0);
      ecc_ctrl_i = 4'd0;
      tick();

      // ---------------- full encode after abort, with stalls ----------------
      start_sector(1'b0, 10'd511);
      stream(1'b1, n_dat, n_par, n_calc);
      check("re_dat_cnt",  n_dat,  512);
      check("re_par_cnt",  n_par,  13);
      check("re_calc_cnt", n_calc, 0);
      check("re_stat",  {31'd0, change_stat_o},  32'd1);
      check("re_error", {31'd0, ecc_error_o},    32'd0);
      check("re_fail",  {31'd0, correct_fail_o}, 32'd0);
      tick();
      check("re_block", {31'd0, ecc_block_o}, 32'd1);

      // ---------------- 1-byte decode sector ----------------
      start_sector(1'b1, 10'd0);
      stream(1'b0, n_dat, n_par, n_calc);
      check("one_dat_cnt",  n_dat,  1);
      check("one_par_cnt",  n_par,  13);
      check("one_calc_cnt", n_calc, 1);
      core_done_i = 1'b1; core_errn_i = 4'd1;
      tick();
      core_done_i = 1'b0; core_errn_i = 4'd0;
      check("one_stat",  {31'd0, change_stat_o}, 32'd1);
      check("one_error", {31'd0, ecc_error_o},   32'd1);
      check("one_cnt",   {28'd0, error_cnt_o},   32'd1);
      tick();

`ifdef BCHECC_TIMEOUT_EN
      // ---------------- CALC timeout ----------------
      start_sector(1'b1, 10'd0);
      stream(1'b0, n_dat, n_par, n_calc);
      n_wait = 0;
      while (!change_stat_o && n_wait < 100) begin
         tick();
         n_wait++;
      end
      check("tmo_cycles", n_wait, 16);
      check("tmo_error",  {31'd0, ecc_error_o},    32'd1);
      check("tmo_fail",   {31'd0, correct_fail_o}, 32'd1);
      check("tmo_cnt",    {28'd0, error_cnt_o},    32'd0);
      tick();
`endif

      // ---------------- async reset mid-sector ----------------
      start_sector(1'b1, 10'd20);
      nfc_vld_i = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      #2;
      rst = 1'b1;
      #1;
      check("arst_busy",  {31'd0, ecc_busy_o},  32'd0);
      check("arst_rdy",   {31'd0, nfc_rdy_o},   32'd0);
      check("arst_error", {31'd0, ecc_error_o}, 32'd0);
      check("arst_cnt",   {28'd0, error_cnt_o}, 32'd0);
      nfc_vld_i = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      check("arst_idle", {31'd0, ecc_busy_o}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
